// File: rtl/intmatmul_host_if.sv
// Operand stream, result stream and matrix-multiply slave bus for intmatmul_host.
interface intmatmul_host_if #(
  parameter int unsigned pWordSize = 4
);
  logic [pWordSize-1:0] InData;
  logic                 InValid;
  logic                 InReady;
  logic [pWordSize-1:0] ResData;
  logic                 ResValid;
  logic                 ResReady;
  logic                 BusRD;
  logic                 BusWR;
  logic [14:0]          BusAddr;
  logic [31:0]          BusWData;
  logic [31:0]          BusRData;

  modport master (
    input  InData, InValid, ResReady, BusRData,
    output InReady, ResData, ResValid, BusRD, BusWR, BusAddr, BusWData
  );

  modport slave (
    output InData, InValid, ResReady, BusRData,
    input  InReady, ResData, ResValid, BusRD, BusWR, BusAddr, BusWData
  );
endinterface

// File: rtl/intmatmul_host.sv
// Host sequencer: streams an N x N matrix and N-vector into a matrix-multiply
// slave, waits, then reads back and emits the N result elements one by one.
module intmatmul_host #(
  parameter int unsigned pVectorSize = 4,
  parameter int unsigned pWordSize   = 4,
  parameter int unsigned pWaitCycles = 2
) (
  input  logic Clk,
  input  logic Reset,
  input  logic Start,
  output logic Busy,
  output logic Done,
  intmatmul_host_if.master io
);
  localparam int unsigned NN = pVectorSize * pVectorSize;
  localparam int unsigned CW = $clog2(NN + 1);
  localparam int unsigned KW = (pVectorSize > 1) ? $clog2(pVectorSize) : 1;

  typedef enum logic [2:0] {IDLE, LOADM, LOADV, WAIT, RDREQ, RDCAP, EMIT, FIN} state_t;

  state_t               state, state_n;
  logic [CW-1:0]        cnt, cnt_n;
  logic [KW-1:0]        k, k_n;
  logic [3:0]           wcnt, wcnt_n;
  logic                 bus_rd, bus_rd_n, bus_wr, bus_wr_n;
  logic [14:0]          bus_addr, bus_addr_n;
  logic [31:0]          bus_wdata, bus_wdata_n;
  logic [pWordSize-1:0] res_data, res_data_n;
  logic                 res_valid, res_valid_n;
  logic                 done, done_n;
  logic                 in_ready, accept;
  logic                 unused_rdata;

  assign in_ready = (state == LOADM) || (state == LOADV);
  assign accept   = in_ready && io.InValid;
  assign unused_rdata = ^io.BusRData;

  // Registered outputs are computed from the upcoming state so that each
  // strobe lines up with the state it belongs to.
  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    k_n         = k;
    wcnt_n      = wcnt;
    bus_rd_n    = 1'b0;
    bus_wr_n    = 1'b0;
    bus_addr_n  = bus_addr;
    bus_wdata_n = bus_wdata;
    res_data_n  = res_data;
    res_valid_n = res_valid;
    done_n      = 1'b0;
    unique case (state)
      IDLE: begin
        if (Start) begin
          state_n = LOADM;
          cnt_n   = '0;
          k_n     = '0;
        end
      end
      LOADM: begin
        if (accept) begin
          bus_wr_n    = 1'b1;
          bus_addr_n  = 15'd0;
          bus_wdata_n = 32'(io.InData);
          if (cnt == CW'(NN - 1)) begin
            state_n = LOADV;
            cnt_n   = '0;
          end else begin
            cnt_n = cnt + 1'b1;
          end
        end
      end
      LOADV: begin
        if (accept) begin
          bus_wr_n    = 1'b1;
          bus_addr_n  = 15'd1;
          bus_wdata_n = 32'(io.InData);
          if (cnt == CW'(pVectorSize - 1)) begin
            state_n = WAIT;
            cnt_n   = '0;
            wcnt_n  = '0;
          end else begin
            cnt_n = cnt + 1'b1;
          end
        end
      end
      WAIT: begin
        if (wcnt == 4'(pWaitCycles)) begin
          state_n    = RDREQ;
          k_n        = '0;
          bus_rd_n   = 1'b1;
          bus_addr_n = '0;
        end else begin
          wcnt_n = wcnt + 1'b1;
        end
      end
      RDREQ: begin
        state_n    = RDCAP;
        bus_rd_n   = 1'b1;
        bus_addr_n = 15'(k);
      end
      RDCAP: begin
        state_n     = EMIT;
        res_data_n  = io.BusRData[pWordSize-1:0];
        res_valid_n = 1'b1;
      end
      EMIT: begin
        if (io.ResReady) begin
          res_valid_n = 1'b0;
          if (k == KW'(pVectorSize - 1)) begin
            state_n = FIN;
            done_n  = 1'b1;
          end else begin
            k_n        = k + 1'b1;
            state_n    = RDREQ;
            bus_rd_n   = 1'b1;
            bus_addr_n = 15'(k + 1'b1);
          end
        end
      end
      FIN: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state     <= IDLE;
      cnt       <= '0;
      k         <= '0;
      wcnt      <= '0;
      bus_rd    <= 1'b0;
      bus_wr    <= 1'b0;
      bus_addr  <= '0;
      bus_wdata <= '0;
      res_data  <= '0;
      res_valid <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      k         <= k_n;
      wcnt      <= wcnt_n;
      bus_rd    <= bus_rd_n;
      bus_wr    <= bus_wr_n;
      bus_addr  <= bus_addr_n;
      bus_wdata <= bus_wdata_n;
      res_data  <= res_data_n;
      res_valid <= res_valid_n;
      done      <= done_n;
    end
  end

  assign Busy        = (state != IDLE);
  assign Done        = done;
  assign io.InReady  = in_ready;
  assign io.BusRD    = bus_rd;
  assign io.BusWR    = bus_wr;
  assign io.BusAddr  = bus_addr;
  assign io.BusWData = bus_wdata;
  assign io.ResData  = res_data;
  assign io.ResValid = res_valid;
endmodule

// File: tb/tb_intmatmul_host.sv
// Randomized scoreboard bench for intmatmul_host with a behavioural slave.
module tb_intmatmul_host;
  localparam int unsigned N = 4;
  localparam int unsigned W = 4;
  localparam int unsigned P = 2;

  logic clk = 1'b0;
  logic rst, start, busy, done;

  intmatmul_host_if #(.pWordSize(W)) io();

  intmatmul_host #(.pVectorSize(N), .pWordSize(W), .pWaitCycles(P)) dut (
    .Clk(clk), .Reset(rst), .Start(start), .Busy(busy), .Done(done), .io(io)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  logic [W-1:0] exp_q[$];
  int cyc = 0;
  int wr0, wr1, wr_first, wr_last, dones = 0;
  bit rd_seen;
  int stall_cycles = 0;
  bit vtog = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Behavioural slave: collects matrix/vector writes, answers reads one cycle later.
  logic [W-1:0] sm[N*N];
  logic [W-1:0] sv[N];
  int swp, svp;

  function automatic logic [W-1:0] slave_elem(input int row);
    int s = 0;
    for (int j = 0; j < N; j++) s += int'(sm[row*N+j]) * int'(sv[j]);
    return W'(s);
  endfunction

  always @(posedge clk) begin
    logic [31:0] rd;
    if (rst || (start && !busy)) begin
      swp <= 0;
      svp <= 0;
    end else if (io.BusWR) begin
      if (io.BusAddr == 15'd0) begin
        sm[swp % (N*N)] <= io.BusWData[W-1:0];
        swp <= swp + 1;
      end else if (io.BusAddr == 15'd1) begin
        sv[svp % N] <= io.BusWData[W-1:0];
        svp <= svp + 1;
      end
    end
    if (io.BusRD) begin
      rd = $urandom;
      rd[W-1:0] = slave_elem(int'(io.BusAddr) % N);
      io.BusRData <= rd;
    end
  end

  // Result consumer: optionally stalls each result for stall_cycles cycles.
  initial begin
    int hold = 0;
    io.ResReady = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (io.ResValid) begin
        if (hold < stall_cycles) begin
          io.ResReady = 1'b0;
          hold++;
        end else begin
          io.ResReady = 1'b1;
        end
      end else begin
        hold = 0;
        io.ResReady = (stall_cycles == 0);
      end
    end
  end

  // Monitor: bus protocol, wait gap, result scoreboard, stall stability, Done.
  initial begin
    logic [W-1:0] held;
    bit holding = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst) begin
        if (io.BusRD && io.BusWR) check("rd_wr_overlap", 1, 0);
        if (io.BusWR) begin
          if (io.BusAddr == 15'd0) begin
            if (wr1 != 0) check("matrix_after_vector", 1, 0);
            wr0++;
          end else if (io.BusAddr == 15'd1) begin
            wr1++;
          end
          if (wr_first < 0) wr_first = cyc;
          wr_last = cyc;
        end
        if (io.BusRD && !rd_seen) begin
          rd_seen = 1'b1;
          check("wait_gap", cyc - wr_last, P + 1);
        end
        if (io.ResValid) begin
          if (holding) check("res_stable", io.ResData, held);
          if (io.ResReady) begin
            if (exp_q.size() == 0) check("unexpected_result", 1, 0);
            else check("result", io.ResData, exp_q.pop_front());
            holding = 1'b0;
          end else begin
            holding = 1'b1;
            held = io.ResData;
          end
        end else begin
          holding = 1'b0;
        end
        if (done) begin
          dones++;
          check("done_after_results", exp_q.size(), 0);
        end
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_inready"}, io.InReady, 0);
    check({tag, "_resvalid"}, io.ResValid, 0);
    check({tag, "_resdata"}, io.ResData, 0);
    check({tag, "_busrd"}, io.BusRD, 0);
    check({tag, "_buswr"}, io.BusWR, 0);
    check({tag, "_busaddr"}, io.BusAddr, 0);
    check({tag, "_buswdata"}, io.BusWData, 0);
  endtask

  // kind: 0 identity/{1,2,3,4}, 1 all fifteen, 2 random.
  task automatic run_txn(input int kind, input bit toggle, input int stall,
                         input int abort_at, input bit poke);
    int mat[N*N];
    int vec[N];
    logic [W-1:0] words[$];
    int dones_before, g;
    for (int i = 0; i < N*N; i++)
      mat[i] = (kind == 0) ? ((i / N == i % N) ? 1 : 0) : (kind == 1) ? 15 : int'($urandom_range(0, 15));
    for (int j = 0; j < N; j++)
      vec[j] = (kind == 0) ? j + 1 : (kind == 1) ? 15 : int'($urandom_range(0, 15));
    for (int i = 0; i < N*N; i++) words.push_back(W'(mat[i]));
    for (int j = 0; j < N; j++) words.push_back(W'(vec[j]));
    for (int r = 0; r < N; r++) begin
      int s = 0;
      for (int j = 0; j < N; j++) s += mat[r*N+j] * vec[j];
      exp_q.push_back(W'(s % (1 << W)));
    end
    stall_cycles = stall;
    wr0 = 0; wr1 = 0; wr_first = -1; wr_last = 0; rd_seen = 1'b0;
    dones_before = dones;

    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    for (int i = 0; i < words.size(); i++) begin
      g = 0;
      forever begin
        io.InData  = words[i];
        io.InValid = toggle ? vtog : 1'b1;
        vtog = ~vtog;
        @(negedge clk);
        if (io.InValid && io.InReady) break;
        g++;
        if (g > 50) begin
          check("in_accept_timeout", 0, 1);
          io.InValid = 1'b0;
          return;
        end
        @(posedge clk); #1;
      end
      @(posedge clk); #1;
      if (abort_at == i + 1) begin
        rst = 1'b1;
        io.InValid = 1'b0;
        @(posedge clk); #1 rst = 1'b0;
        exp_q.delete();
        @(negedge clk);
        check_reset_outputs("abort");
        return;
      end
    end
    // A poking transaction keeps InValid high and pulses Start while busy.
    io.InValid = poke;
    io.InData  = W'($urandom);
    if (poke) begin
      start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      g = 0;
      while (!io.ResValid && g < 100) begin
        @(posedge clk); #1;
        g++;
      end
      start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
    end
    g = 0;
    while (dones == dones_before && g < 300) begin
      @(negedge clk);
      g++;
    end
    if (g >= 300) check("done_timeout", 0, 1);
    repeat (20) @(negedge clk);
    io.InValid = 1'b0;
    check("done_count", dones - dones_before, 1);
    check("idle_after", busy, 0);
    check("wr_matrix", wr0, N*N);
    check("wr_vector", wr1, N);
    if (!toggle) check("wr_consecutive", wr_last - wr_first, N*N + N - 1);
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    io.InValid = 1'b0;
    io.InData = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_reset_outputs("reset");

    run_txn(0, 1'b0, 0, 0, 1'b0);
    run_txn(1, 1'b0, 0, 0, 1'b0);
    run_txn(0, 1'b1, 5, 0, 1'b0);
    run_txn(2, 1'b0, 0, 7, 1'b0);
    run_txn(2, 1'b0, 0, 0, 1'b0);
    run_txn(2, 1'b1, 3, 0, 1'b1);
    for (int t = 0; t < 4; t++)
      run_txn(2, 1'($urandom_range(0, 1)), int'($urandom_range(0, 3)), 0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/intmatmul_host.md
INTMATMUL_HOST -- requirements
Module: intmatmul_host

Interface
REQ-001 Parameter pVectorSize, default 4: vector length N; matrix is N x N.
REQ-002 Parameter pWordSize, default 4: element width W.
REQ-003 Parameter pWaitCycles, default 2, legal 1..15: idle cycles between last vector write and first read.
REQ-004 Port Clk  input  1  sole clock; all logic on rising edge.
REQ-005 Port Reset  input  1  synchronous, active-high reset.
REQ-006 Port Start  input  1  begin one load/compute/read transaction; sampled only in IDLE.
REQ-007 Port Busy  output  1  high in every state except IDLE.
REQ-008 Port Done  output  1  one-cycle pulse when the transaction completes.
REQ-009 Port InData  input  W  operand word (matrix words first, then vector words).
REQ-010 Port InValid  input  1  InData valid.
REQ-011 Port InReady  output  1  host accepts InData; transfer when InValid && InReady at a clock edge.
REQ-012 Port ResData  output  W  result element.
REQ-013 Port ResValid  output  1  ResData valid; held with ResData stable until accepted.
REQ-014 Port ResReady  input  1  result consumer ready; transfer when ResValid && ResReady.
REQ-015 Port BusRD  output  1  read strobe to the matrix-multiply slave.
REQ-016 Port BusWR  output  1  write strobe to the slave.
REQ-017 Port BusAddr  output  15  slave address.
REQ-018 Port BusWData  output  32  write data to slave; InData zero-extended to 32 bits.
REQ-019 Port BusRData  input  32  slave read data; bits [W-1:0] used, rest ignored.

Function
REQ-020 States: IDLE, LOADM, LOADV, WAIT, RDREQ, RDCAP, EMIT, FIN.
REQ-021 All Bus* outputs, ResData, ResValid, Done are registered.
REQ-022 IDLE: InReady=0, bus strobes 0; Start=1 -> LOADM, word counter cleared.
REQ-023 LOADM: InReady=1; each accepted word at edge t drives BusWR=1, BusAddr=0, BusWData=InData for exactly cycle t+1.
REQ-024 After the N*N-th matrix word is accepted -> LOADV, counter cleared; no bubble required.
REQ-025 LOADV: InReady=1; each accepted word drives one-cycle BusWR=1, BusAddr=1 in the next cycle.
REQ-026 After the N-th vector word is accepted -> WAIT; its write occurs in the first WAIT cycle.
REQ-027 WAIT lasts pWaitCycles+1 cycles with InReady=0, then -> RDREQ with read index k=0.
REQ-028 RDREQ (1 cycle): BusRD=1, BusAddr=k; -> RDCAP.
REQ-029 RDCAP (1 cycle): BusRD=1, BusAddr=k held; BusRData[W-1:0] captured into ResData at cycle end; -> EMIT with ResValid=1.
REQ-030 EMIT: ResValid=1 until ResReady; on transfer ResValid=0; k<N-1 -> k+1, RDREQ; k=N-1 -> FIN.
REQ-031 FIN: Done=1 for one cycle; -> IDLE.
REQ-032 BusRD and BusWR never high in the same cycle; both 0 outside the states above.
REQ-033 Start while Busy=1 ignored; InValid in IDLE/WAIT/RDREQ/RDCAP/EMIT ignored (InReady=0).
REQ-034 Word counters sized ceil(log2(N*N+1)); no wrap within a transaction.
REQ-035 ResData element k equals slave output element k (row k dot vector), W-bit modulo result.

Reset
REQ-036 Reset=1 at an edge: state IDLE, counters and k = 0, Busy=0, Done=0, InReady=0, ResValid=0, ResData=0, BusRD=0, BusWR=0, BusAddr=0, BusWData=0.
REQ-037 Reset mid-transaction abandons it with no further bus strobes; slave register contents undefined to the host; Start accepted on first non-reset cycle.

Verification
REQ-038 N=4,W=4, InValid always 1, Start pulse: exactly 16 BusWR at Addr 0 then 4 at Addr 1 on consecutive cycles; first RD is pWaitCycles+1 cycles after last WR.
REQ-039 Matrix = identity, vector = {1,2,3,4}, ResReady=1: ResData sequence 1,2,3,4; Done pulses once after the fourth transfer.
REQ-040 All matrix and vector elements = 15: each result = (4*225) mod 16 = 4.
REQ-041 InValid toggled every other cycle and ResReady held low 5 cycles per result: strobe count unchanged, ResData held stable while stalled, same results as REQ-039.
REQ-042 Reset asserted during LOADM after 7 words: all outputs at reset values next cycle; new Start completes a full correct transaction.
REQ-043 Start pulsed during WAIT and EMIT: no effect; exactly one Done per accepted Start.
